// File: rtl/ascii_7seg_pkg.sv
// Shared constants for the ASCII 7-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a}, active-high.
package ascii_7seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BLANK = 8'h20;

    localparam seg7_t SEG_0     = 7'h3F;
    localparam seg7_t SEG_1     = 7'h06;
    localparam seg7_t SEG_2     = 7'h5B;
    localparam seg7_t SEG_3     = 7'h4F;
    localparam seg7_t SEG_4     = 7'h66;
    localparam seg7_t SEG_5     = 7'h6D;
    localparam seg7_t SEG_6     = 7'h7D;
    localparam seg7_t SEG_7     = 7'h07;
    localparam seg7_t SEG_8     = 7'h7F;
    localparam seg7_t SEG_9     = 7'h6F;
    localparam seg7_t SEG_A     = 7'h77;
    localparam seg7_t SEG_B     = 7'h7C;
    localparam seg7_t SEG_C     = 7'h39;
    localparam seg7_t SEG_D     = 7'h5E;
    localparam seg7_t SEG_E     = 7'h79;
    localparam seg7_t SEG_F     = 7'h71;
    localparam seg7_t SEG_DASH  = 7'h40;
    localparam seg7_t SEG_UNDER = 7'h08;
    localparam seg7_t SEG_BLANK = 7'h00;

    function automatic seg7_t hex_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_seg = SEG_0;
            4'h1: hex_seg = SEG_1;
            4'h2: hex_seg = SEG_2;
            4'h3: hex_seg = SEG_3;
            4'h4: hex_seg = SEG_4;
            4'h5: hex_seg = SEG_5;
            4'h6: hex_seg = SEG_6;
            4'h7: hex_seg = SEG_7;
            4'h8: hex_seg = SEG_8;
            4'h9: hex_seg = SEG_9;
            4'hA: hex_seg = SEG_A;
            4'hB: hex_seg = SEG_B;
            4'hC: hex_seg = SEG_C;
            4'hD: hex_seg = SEG_D;
            4'hE: hex_seg = SEG_E;
            default: hex_seg = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/ascii_seg_decode.sv
// ASCII byte to active-high 7-segment pattern; unknown codes are blank.
module ascii_seg_decode
    import ascii_7seg_pkg::*;
(
    input  logic [7:0] ascii,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (ascii[7:4] == 4'h3 && ascii[3:0] <= 4'd9) begin
            seg = hex_seg(ascii[3:0]);
        end else begin
            case (ascii)
                8'h41, 8'h61: seg = SEG_A;
                8'h42, 8'h62: seg = SEG_B;
                8'h43, 8'h63: seg = SEG_C;
                8'h44, 8'h64: seg = SEG_D;
                8'h45, 8'h65: seg = SEG_E;
                8'h46, 8'h66: seg = SEG_F;
                8'h2D:        seg = SEG_DASH;
                8'h5F:        seg = SEG_UNDER;
                default:      seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ascii_7seg_scan_display.sv
// Multiplexed 7-segment driver fed by a byte stream (BS/CR aware).
// Optional per-digit blinking when ASCII_7SEG_BLINK_EN is defined.
module ascii_7seg_scan_display
    import ascii_7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 12500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
`ifdef ASCII_7SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 250
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  char_valid,
    input  logic [7:0]            char_data,
    output logic                  char_ready,
    input  logic                  clear,
`ifdef ASCII_7SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output seg7_t                 seg,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam seg7_t                 SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic                        accept;
    logic                        pend_vld;
    logic [7:0]                  pend_byte;
    logic [NUM_DIGITS-1:0][7:0]  char_buf, buf_nxt;
    logic [PS_W-1:0]             prescale;
    logic [IDX_W-1:0]            idx;
    logic                        tc;
    logic [NUM_DIGITS-1:0]       onehot;
    seg7_t                       seg_raw;
    logic                        blank_sel;

    assign accept = char_valid & char_ready;

    // Ready drops for the cycle after each accept, giving one char per two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_ready <= 1'b1;
            pend_vld   <= 1'b0;
            pend_byte  <= 8'h00;
        end else begin
            char_ready <= ~accept;
            pend_vld   <= accept & ~clear;
            if (accept) pend_byte <= char_data;
        end
    end

    always_comb begin
        buf_nxt = char_buf;
        if (clear) begin
            buf_nxt = {NUM_DIGITS{BLANK}};
        end else if (pend_vld) begin
            case (pend_byte)
                BS: begin
                    for (int i = 0; i < NUM_DIGITS - 1; i++) buf_nxt[i] = char_buf[i+1];
                    buf_nxt[NUM_DIGITS-1] = BLANK;
                end
                CR: buf_nxt = {NUM_DIGITS{BLANK}};
                default: begin
                    for (int i = NUM_DIGITS - 1; i > 0; i--) buf_nxt[i] = char_buf[i-1];
                    buf_nxt[0] = pend_byte;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) char_buf <= {NUM_DIGITS{BLANK}};
        else        char_buf <= buf_nxt;
    end

    assign tc = (prescale == PS_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            idx      <= '0;
        end else begin
            prescale <= tc ? '0 : prescale + PS_W'(1);
            if (tc) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    ascii_seg_decode u_dec (
        .ascii (char_buf[idx]),
        .seg   (seg_raw)
    );

`ifdef ASCII_7SEG_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FR_W-1:0] frame_cnt;
    logic            blink_on;

    // A frame completes when the last digit's slot times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tc && idx == IDX_W'(NUM_DIGITS - 1)) begin
            if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
            end
        end
    end

    assign blank_sel = ~blink_on & blink_mask[idx];
`else
    assign blank_sel = 1'b0;
`endif

    assign onehot = NUM_DIGITS'(1) << idx;

    // The slot boundary cycle drives no digit so the old pattern never ghosts onto the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= SEG_OFF;
            dig_en <= DIG_OFF;
        end else begin
            seg    <= (blank_sel ? SEG_BLANK : seg_raw) ^ SEG_OFF;
            dig_en <= tc ? DIG_OFF : (onehot ^ DIG_OFF);
        end
    end

endmodule

// File: tb/tb_ascii_7seg_scan_display.sv
// Bench for ascii_7seg_scan_display: directed vectors plus a per-cycle reference model.
module tb_ascii_7seg_scan_display;

    localparam int N = 4;
    localparam int S = 4;

    localparam logic [6:0] HEXSEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [3:0] SCAN_SEQ [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                             4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          char_valid;
    logic [7:0]    char_data;
    logic          char_ready;
    logic          clear;
    logic [6:0]    seg;
    logic [N-1:0]  dig_en;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    ascii_7seg_scan_display #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (S),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
`ifdef ASCII_7SEG_BLINK_EN
        ,
        .BLINK_FRAMES   (2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear      (clear),
`ifdef ASCII_7SEG_BLINK_EN
        .blink_mask ({N{1'b0}}),
`endif
        .seg        (seg),
        .dig_en     (dig_en)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [7:0] c);
        logic [7:0] lc;
        lc = c | 8'h20;
        if (c >= 8'h30 && c <= 8'h39) return HEXSEG[c - 8'h30];
        if (lc >= 8'h61 && lc <= 8'h66) return HEXSEG[lc - 8'h61 + 8'd10];
        if (c == 8'h2D) return 7'h40;
        if (c == 8'h5F) return 7'h08;
        return 7'h00;
    endfunction

    // Reference model: edge count since reset gives slot and digit; buffer kept as a byte array.
    int         m_n;
    bit         m_ready;
    bit         m_pend_v;
    logic [7:0] m_pend;
    logic [7:0] m_buf [N];
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_ready = 1'b1; m_pend_v = 1'b0; m_pend = 8'h00;
            for (int i = 0; i < N; i++) m_buf[i] = 8'h20;
            exp_dig = 4'hF; exp_seg = 7'h7F;
        end else begin
            int  slot, dg;
            bit  acc;
            slot = m_n % S;
            dg   = (m_n / S) % N;
            if (slot == S - 1) exp_dig = 4'hF;
            else begin
                exp_dig = ~(4'b0001 << dg);
                exp_seg = ~ref_seg(m_buf[dg]);
            end
            acc = char_valid && m_ready;
            if (clear) begin
                for (int i = 0; i < N; i++) m_buf[i] = 8'h20;
            end else if (m_pend_v) begin
                if (m_pend == 8'h08) begin
                    for (int i = 0; i < N - 1; i++) m_buf[i] = m_buf[i+1];
                    m_buf[N-1] = 8'h20;
                end else if (m_pend == 8'h0D) begin
                    for (int i = 0; i < N; i++) m_buf[i] = 8'h20;
                end else begin
                    for (int i = N - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
                    m_buf[0] = m_pend;
                end
            end
            m_pend_v = acc && !clear;
            if (acc) m_pend = char_data;
            m_ready = !acc;
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("model_dig_en", dig_en, exp_dig);
            check("model_ready", char_ready, m_ready);
            if (exp_dig != 4'hF) check("model_seg", seg, exp_seg);
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1 with ready expected high; leaves char_valid asserted.
    task automatic send(input logic [7:0] b);
        char_valid = 1'b1;
        char_data  = b;
        @(negedge clk); check("ready_hi", char_ready, 1);
        @(posedge clk); #1;
        @(negedge clk); check("ready_lo", char_ready, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_dig(input logic [3:0] want, input string name);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dig_en == want) break;
        end
        if (k == 40) check({name, "_timeout"}, dig_en, want);
    endtask

    task automatic wait_show(input int d, input logic [6:0] want, input string name);
        logic [3:0] en;
        en = ~(4'b0001 << d);
        wait_dig(en, name);
        check(name, seg, want);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; char_valid = 1'b0; char_data = 8'h00; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run = 1'b1;

        // Asynchronous reset mid-scan
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_seg", seg, 7'h7F);
        check("rst_dig", dig_en, 4'hF);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check("rst_ready", char_ready, 1);

        // "1234" with valid held high
        sync();
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        char_valid = 1'b0;
        wait_show(0, 7'b0011001, "t2_d0_4");
        wait_show(3, 7'b1111001, "t2_d3_1");

        // Shift in '5', then backspace
        sync();
        send(8'h35);
        char_valid = 1'b0;
        wait_show(3, 7'b0100100, "t3_d3_2");
        wait_show(0, 7'b0010010, "t3_d0_5");
        sync();
        send(8'h08);
        char_valid = 1'b0;
        wait_show(0, 7'b0011001, "t3_bs_d0_4");
        wait_show(3, 7'h7F, "t3_bs_d3_blank");

        // Clear coincident with a handshake of 'A'
        sync();
        char_valid = 1'b1; char_data = 8'h41; clear = 1'b1;
        @(negedge clk); check("t4_ready1", char_ready, 1);
        @(posedge clk); #1 clear = 1'b0; char_valid = 1'b0;
        @(negedge clk); check("t4_ready0", char_ready, 0);
        @(negedge clk); check("t4_ready1b", char_ready, 1);
        for (int d = 0; d < N; d++) wait_show(d, 7'h7F, "t4_blank");

        // Letters and punctuation, then CR
        sync();
        send(8'h62); send(8'h2D); send(8'h5F); send(8'h45);
        char_valid = 1'b0;
        wait_show(0, 7'b0000110, "t6_d0_E");
        wait_show(1, 7'b1110111, "t6_d1_under");
        wait_show(2, 7'b0111111, "t6_d2_dash");
        wait_show(3, 7'b0000011, "t6_d3_b");
        sync();
        send(8'h0D);
        char_valid = 1'b0;
        wait_show(0, 7'h7F, "t6_cr_d0");
        wait_show(3, 7'h7F, "t6_cr_d3");

        // Scan order and anti-ghost gap
        wait_dig(4'h7, "t5_sync7");
        wait_dig(4'hF, "t5_syncF");
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("t5_scan", dig_en, SCAN_SEQ[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascii_7seg_scan_display.md
Name: ascii_7seg_scan_display

Overview:
Multi-digit, time-multiplexed 7-segment display driver fed by the UART receive path.
- Accepts ASCII characters over a valid/ready handshake into a NUM_DIGITS-deep shift buffer.
- Decodes each buffered character to segment patterns and scans the digits one at a time on common-enable lines.
- Handles control codes: backspace and carriage return.
- Sits between the UART RX byte output and the board's 7-segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 12500, clock cycles each digit stays enabled (>=2)
SEG_ACTIVE_LOW, 1, 1: seg outputs are low-true; 0: high-true
DIG_ACTIVE_LOW, 1, 1: dig_en outputs are low-true; 0: high-true

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
char_valid  in  1  char_data holds a character to load
char_data  in  8  ASCII byte
char_ready  out  1  block can accept a character this cycle
clear  in  1  synchronous clear of the character buffer
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dig_en  out  NUM_DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW; bit 0 = rightmost digit

Behaviour:
- Reset (async, rst_n=0):
  - Every buffer entry = 8'h20 (blank).
  - Prescaler = 0, digit index = 0, pending register empty, char_ready = 1.
  - seg = all segments off; dig_en = all digits off, at the configured polarities.
- Handshake:
  - A transfer occurs when char_valid && char_ready.
  - The byte is captured into a pending register and char_ready drops the next cycle.
  - The pending byte is applied to the buffer in the following cycle; char_ready returns high the cycle after.
  - Throughput: 1 char per 2 cycles. The buffer is updated 2 cycles after acceptance.
- Applying a pending byte:
  - 8'h08 (BS): shift buffer right. buf[i] <= buf[i+1]; buf[NUM_DIGITS-1] <= 8'h20.
  - 8'h0D (CR): all entries <= 8'h20.
  - Any other byte: shift left. buf[i+1] <= buf[i]; buf[0] <= byte. The oldest character is discarded; there is no overflow flag.
- clear:
  - Takes priority. When clear=1, all entries <= 8'h20 that cycle and any pending byte is discarded.
  - A handshake in the same cycle completes (char_ready unaffected) but its byte is dropped.
- Decode (combinational on the selected entry):
  - '0'-'9' → standard digits.
  - 'A'/'a' A, 'B'/'b' b, 'C'/'c' C, 'D'/'d' d, 'E'/'e' E, 'F'/'f' F.
  - '-' (8'h2D) → segment g only.
  - '_' (8'h5F) → segment d only.
  - All other codes, including 8'h20 → blank.
  - Active-high patterns are inverted when SEG_ACTIVE_LOW=1.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances.
  - The digit index wraps from NUM_DIGITS-1 to 0.
  - Anti-ghosting: on the cycle the index changes, dig_en is forced all-off for exactly 1 cycle.
  - seg and dig_en are registered: 1-cycle latency from index/buffer to pins.
  - A buffer update is visible on the pins when that digit is next enabled.
- NUM_DIGITS=1: the index stays at 0. The blank cycle still occurs every SCAN_DIV cycles.

Optional Feature:
ASCII_7SEG_BLINK_EN
- Defined:
  - Adds input blink_mask [NUM_DIGITS-1:0] and parameter BLINK_FRAMES (default 250).
  - A frame counter counts completed scans of all digits. A blink phase bit toggles every BLINK_FRAMES frames; reset phase = on.
  - During the off phase, digits with blink_mask[i]=1 drive all segments off while enabled.
- Undefined: the port, parameter, counter and phase logic are absent, and all digits are always shown.

Decomposition:
- Package ascii_7seg_pkg holds:
  - ASCII control constants: BS=8'h08, CR=8'h0D, BLANK=8'h20.
  - Active-high segment pattern constants, including SEG_BLANK and SEG_DASH.
  - The typedef for a 7-bit segment vector.
- Sub-module ascii_seg_decode: pure combinational ASCII → active-high 7-bit pattern.
  - Instantiated once on the selected entry.
  - Reused by the next UART display blocks.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, active-low outputs.
1. Reset: rst_n=0 mid-scan → seg=7'h7F and dig_en=4'hF immediately (async); char_ready=1 after release.
2. Send '1','2','3','4' with char_valid held high → char_ready toggles 1,0 per char. On scan, digit0 seg=7'b0011001 ('4') and digit3 seg=7'b1111001 ('1').
3. Buffer "1234", then send '5' → buffer "2345". Then send 8'h08 → digit3 blank and digit0 shows '4' (7'b0011001).
4. Assert clear in the same cycle as a handshake of 'A' → all digits blank. char_ready follows the normal 1,0,1 pattern and 'A' never appears.
5. Scan timing: dig_en sequence 4'hE (4 cycles, including the 1 blank cycle as 4'hF at each change), then 4'hD, 4'hB, 4'h7, wrapping back to 4'hE. Each period is 4 cycles.
6. With ASCII_7SEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 → digit0 seg=7'h7F for 2 frames, then shows its character for 2 frames; other digits are unaffected.
